// File: rtl/if_stage.sv
// Instruction fetch: PC, imem req/ready handshake, IF/ID register.
// Latency: one cycle from imem accept to IF/ID; 1 instr/cycle with zero-wait memory.
// Backpressure: PCWrite/IFIDWrite stall park a fetched word in buf; branch_taken overrides stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFIDpc,
  output logic [31:0] IFIDinstr,
  output logic        IFIDvalid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] target_aligned;
  logic        advance;

  assign target_aligned = branch_target & 32'hFFFF_FFFC;
  // PCWrite without IFIDWrite is treated as a stall.
  assign advance        = PCWrite & IFIDWrite;

  // DROP keeps presenting the abandoned address until its response is consumed.
  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = (state == DROP) ? req_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'h0;
      IFIDpc    <= 32'h0;
      IFIDinstr <= NOP_INSTR;
      IFIDvalid <= 1'b0;
    end else if (branch_taken) begin
      pc        <= target_aligned;
      IFIDinstr <= NOP_INSTR;
      IFIDvalid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'h0;
      case (state)
        REQ: begin
          if (!imem_ready) begin
            req_addr <= pc;
            state    <= DROP;
          end
        end
        DROP:    state <= DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) begin
            if (advance) begin
              IFIDinstr <= imem_rdata;
              IFIDpc    <= pc;
              IFIDvalid <= 1'b1;
              pc        <= pc + 32'd4;
            end else begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc;
              state     <= HOLD;
            end
          end else if (IFIDWrite) begin
            IFIDinstr <= NOP_INSTR;
            IFIDvalid <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            IFIDinstr <= buf_instr;
            IFIDpc    <= buf_pc;
            IFIDvalid <= 1'b1;
            pc        <= pc + 32'd4;
            state     <= REQ;
          end
        end
        DROP: begin
          IFIDinstr <= NOP_INSTR;
          IFIDvalid <= 1'b0;
          if (imem_ready) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model returns an address-derived word; committed IF/ID entries are scoreboarded.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, IFIDWrite, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IFIDpc, IFIDinstr;
  logic        IFIDvalid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .IFIDpc(IFIDpc), .IFIDinstr(IFIDinstr), .IFIDvalid(IFIDvalid)
  );

  // 0 -> 0x00500093, 4 -> 0x00A00113, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a >> 2) * 32'h0050_0080;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a);
    sb_q.push_back({a, mem_word(a)});
  endtask

  // A write into IF/ID that leaves it valid is a commit of the next expected fetch.
  always @(posedge clk) begin
    logic wr;
    logic [63:0] exp;
    wr = IFIDWrite && !branch_taken && rst_n;
    #1;
    if (wr && IFIDvalid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {IFIDpc, IFIDinstr}, 64'h0);
      end else begin
        exp = sb_q.pop_front();
        check("sb_commit", {IFIDpc, IFIDinstr}, exp);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b1;
    cyc(); cyc();
    check("rst_req",   {63'h0, imem_req}, 64'h0);
    check("rst_addr",  {32'h0, imem_addr}, 64'h0);
    check("rst_ifid",  {IFIDpc, IFIDinstr}, {32'h0, NOP});
    check("rst_valid", {63'h0, IFIDvalid}, 64'h0);

    // Zero-wait streaming
    rst_n = 1'b1;
    cyc();
    check("first_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    push(32'h0); push(32'h4);
    cyc(); cyc();

    // Load-use stall with IFIDpc at 0x4
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    push(32'h8);
    cyc();
    check("stall_req", {63'h0, imem_req}, 64'h0);
    check("stall_hold", {IFIDpc, IFIDinstr}, {32'h4, mem_word(32'h4)});
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    push(32'hC);
    cyc();
    check("after_hold_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hC});
    cyc();

    // Wait-state memory at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ws_addr", {32'h0, imem_addr}, {32'h0, 32'h10});
      check("ws_bubble", {31'h0, IFIDvalid, IFIDinstr}, {31'h0, 1'b0, NOP});
    end
    imem_ready = 1'b1;
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
    repeat (4) cyc();
    check("pre_branch_addr", {32'h0, imem_addr}, {32'h0, 32'h20});

    // Branch while fetch of 0x20 is pending
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h103;
    cyc();
    branch_taken = 1'b0;
    check("drop_addr0", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h20});
    check("drop_valid0", {63'h0, IFIDvalid}, 64'h0);
    cyc();
    check("drop_addr1", {32'h0, imem_addr}, {32'h0, 32'h20});
    imem_ready = 1'b1;
    cyc();
    check("redirect_addr", {32'h0, imem_addr}, {32'h0, 32'h100});
    check("redirect_valid", {63'h0, IFIDvalid}, 64'h0);
    push(32'h100);
    cyc();
    check("target_next", {32'h0, imem_addr}, {32'h0, 32'h104});

    // Branch and stall together while in HOLD
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    cyc();
    check("hold_req", {63'h0, imem_req}, 64'h0);
    branch_taken = 1'b1; branch_target = 32'h200;
    cyc();
    branch_taken = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;
    check("hold_br_valid", {63'h0, IFIDvalid}, 64'h0);
    check("hold_br_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h200});
    push(32'h200); push(32'h204);
    cyc(); cyc();

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",   {63'h0, imem_req}, 64'h0);
    check("arst_addr",  {32'h0, imem_addr}, 64'h0);
    check("arst_ifid",  {IFIDpc, IFIDinstr}, {32'h0, NOP});
    check("arst_valid", {63'h0, IFIDvalid}, 64'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("restart_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    push(32'h0);
    cyc();

    // Branch with ready=1 to top of address space, then PC wraps
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    cyc();
    branch_taken = 1'b0;
    check("wrap_target", {32'h0, imem_addr}, {32'h0, 32'hFFFF_FFFC});
    check("wrap_valid", {63'h0, IFIDvalid}, 64'h0);
    push(32'hFFFF_FFFC); push(32'h0);
    cyc();
    check("wrap_addr", {32'h0, imem_addr}, {32'h0, 32'h0});
    cyc();
    check("wrap_after", {32'h0, imem_addr}, {32'h0, 32'h4});

    check("sb_drain", {32'h0, 32'(sb_q.size())}, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Writes the fetched instruction and its PC into IF/ID.
- Obeys PCWrite/IFIDWrite from the hazard detection unit and flushes on a taken branch resolved in EX. Sits directly upstream of ID and of hazard_detect's IFIDrs1/IFIDrs2 inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) inserted on bubble/flush

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
PCWrite  input  1  from hazard_detect; 0 = hold PC
IFIDWrite  input  1  from hazard_detect; 0 = hold IF/ID register
branch_taken  input  1  EX-stage redirect; overrides stall
branch_target  input  32  redirect address; bits [1:0] forced to 0
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ready=0
imem_ready  input  1  memory accepts request; imem_rdata valid same cycle
imem_rdata  input  32  fetched instruction
IFIDpc  output  32  PC of instruction in IF/ID
IFIDinstr  output  32  instruction in IF/ID (rs1=[19:15], rs2=[24:20] to hazard_detect)
IFIDvalid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=IDLE, req_addr=RESET_PC.
  - IFIDpc=0, IFIDinstr=NOP_INSTR, IFIDvalid=0.
  - buf_instr=NOP_INSTR, buf_pc=0; imem_req=0.
  - Reset mid-transaction abandons any outstanding request; the memory side must tolerate the dropped req.
- States:
  - IDLE: imem_req=0; next cycle go to REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; a fetched instruction waits in buf.
  - DROP: imem_req=1, imem_addr=req_addr (stale); waits to discard a response.
- REQ, no branch:
  - ready=1, PCWrite=1, IFIDWrite=1: IFIDinstr<=rdata, IFIDpc<=pc, IFIDvalid<=1, pc<=pc+4, stay REQ. Throughput is 1 instr/cycle with zero-wait memory.
  - ready=1 and (PCWrite=0 or IFIDWrite=0): buf_instr<=rdata, buf_pc<=pc; IF/ID and pc unchanged; go to HOLD.
  - ready=0, IFIDWrite=1: IFIDinstr<=NOP_INSTR, IFIDvalid<=0 (bubble); pc unchanged; stay REQ.
  - ready=0, IFIDWrite=0: IF/ID held; stay REQ.
- HOLD, no branch:
  - PCWrite=1 and IFIDWrite=1: IF/ID<=buf (valid=1), pc<=pc+4, go to REQ.
  - Otherwise hold everything.
- branch_taken=1 has priority over stall in every state:
  - Common actions: pc<=branch_target&~3, IFIDinstr<=NOP_INSTR, IFIDvalid<=0, buf discarded.
  - REQ with ready=1: response discarded, stay REQ.
  - REQ with ready=0: req_addr<=pc (old), go to DROP.
  - HOLD: go to REQ.
  - DROP: stay DROP; pc takes the newest target.
  - IDLE: pc loaded, go to REQ.
- DROP, no branch:
  - ready=1: response discarded, go to REQ.
  - Otherwise stay.
  - IF/ID stays a bubble while in DROP, regardless of IFIDWrite.
- PC arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- PCWrite=1 with IFIDWrite=0 is treated as a stall (no advance); hazard_detect drives both together.

Test Plan:
- Reset then zero-wait memory (ready=1 always), rdata=0x00500093,0x00A00113,…
  - First req cycle after rst_n rises: imem_addr=0x0.
  - IFIDpc 0x0,0x4,0x8 on consecutive cycles, IFIDvalid=1.
- Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle while IFIDpc=0x4.
  - IFIDpc/IFIDinstr held at 0x4.
  - Fetched 0x8 word buffered (HOLD, imem_req=0).
  - Next cycle IFIDpc=0x8 with correct instruction, then fetch 0xC.
- Wait-state memory: ready low 3 cycles at addr 0x10.
  - imem_addr stable at 0x10, IFIDvalid=0 with NOP_INSTR.
  - Advances on the ready cycle.
- Branch during pending fetch: ready=0 at addr 0x20, branch_taken=1 target 0x103.
  - DROP with imem_addr=0x20 until ready; that response discarded.
  - Then imem_addr=0x100, IFIDvalid=0 meanwhile.
- Branch and stall in the same cycle in HOLD: branch wins.
  - Buffer discarded, IFIDvalid=0, next imem_addr=target.
- Async reset asserted mid-REQ: outputs return to reset values immediately, without waiting for a clock edge.
  - Fetch restarts at RESET_PC.
